// File: rtl/da_pkg.sv
// Shared definitions for the bit-serial distributed-arithmetic dot-product engine.
//  - COS16    : 16-entry Q1.17 cosine table; it is the coefficient table's reset contents
//  - da_state_e : engine FSM states (IDLE, RUN, DONE)
//  - clog2_safe / acc_width : accumulator sizing helpers, usable in constant expressions
package da_pkg;

  localparam int COS16 [16] = '{
    131072,  121094,  92681,  50159,       0,  -50159,  -92681, -121094,
   -131072, -121094, -92681, -50159,       0,   50159,   92681,  121094
  };

  typedef enum logic [1:0] {IDLE, RUN, DONE} da_state_e;

  // Returns 0 for n<=1 instead of misbehaving on degenerate sizes.
  function automatic int clog2_safe(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

  // Exact worst-case width of sum_k C[k]*X[k]; the accumulator never wraps.
  function automatic int acc_width(input int coef_w, input int in_w, input int n_taps);
    return coef_w + in_w + clog2_safe(n_taps);
  endfunction

endpackage

// File: rtl/da_plane_sum.sv
// Combinational bit-plane adder tree: sums the coefficients whose sample bit is set
// in the current plane, each sign-extended to the accumulator width.
//  coef_i : N_TAPS packed signed coefficients
//  bit_i  : one bit per tap from the current sample bit-plane
//  sum_o  : signed ACC_W-bit partial sum
module da_plane_sum
  import da_pkg::*;
#(
  parameter int N_TAPS = 16,
  parameter int COEF_W = 19,
  parameter int ACC_W  = 31
) (
  input  logic [N_TAPS-1:0][COEF_W-1:0] coef_i,
  input  logic [N_TAPS-1:0]             bit_i,
  output logic signed [ACC_W-1:0]       sum_o
);

  always_comb begin
    sum_o = '0;
    for (int k = 0; k < N_TAPS; k++)
      if (bit_i[k])
        sum_o = sum_o + {{(ACC_W-COEF_W){coef_i[k][COEF_W-1]}}, coef_i[k]};
  end

endmodule

// File: rtl/da_dot_serial.sv
// Bit-serial distributed-arithmetic inner product: out = sum_k C[k]*X[k].
// One bit-plane per cycle (MSB first) feeds a single shared adder tree, IN_W RUN cycles per vector.
// Ports:
//  clk, rst_n                       clock, synchronous active-low reset
//  in_valid/in_ready/in_data        sample vector handshake, X[k] = in_data[k*IN_W +: IN_W]
//  coef_we/coef_addr/coef_wdata     coefficient write port (IDLE only)
//  coef_err                         1-cycle pulse after a rejected write
//  out_valid/out_ready/out_data     result handshake, out_data held while waiting
//  sat_flag                         sticky saturation flag (DA_ROUND_EN builds only)
// Build option: define DA_ROUND_EN for round-half-up + saturation instead of floor + wrap.
module da_dot_serial
  import da_pkg::*;
#(
  parameter int N_TAPS    = 16,
  parameter int IN_W      = 8,
  parameter int COEF_W    = 19,
  parameter int SIGNED_IN = 1,
  parameter int SHIFT     = 2,
  parameter int OUT_W     = 28,
  localparam int ACC_W    = acc_width(COEF_W, IN_W, N_TAPS),
  localparam int AW       = $clog2(N_TAPS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_TAPS*IN_W-1:0]   in_data,
  input  logic                     coef_we,
  input  logic [AW-1:0]            coef_addr,
  input  logic [COEF_W-1:0]        coef_wdata,
  output logic                     coef_err,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_W-1:0]         out_data
`ifdef DA_ROUND_EN
  ,
  output logic                     sat_flag
`endif
);

  localparam int PW = clog2_safe(IN_W + 1);
  // Scaling is done two bits wider than either operand so rounding cannot overflow.
  localparam int WW = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 2;

  da_state_e                     state_q, state_d;
  logic [N_TAPS-1:0][IN_W-1:0]   x_q, x_d;
  logic [N_TAPS-1:0][COEF_W-1:0] coef_q;
  logic signed [ACC_W-1:0]       acc_q, acc_d, acc_step;
  logic [PW-1:0]                 plane_q, plane_d;
  logic [OUT_W-1:0]              out_q, out_d, res;
  logic                          err_q;
  logic [N_TAPS-1:0]             bits;
  logic signed [ACC_W-1:0]       psum;
  logic signed [WW-1:0]          wide;
  logic                          addr_ok, wr_ok, first_plane;

  // Full-range address space needs no bound check.
  if (N_TAPS == (1 << AW)) begin : g_addr_full
    assign addr_ok = 1'b1;
  end else begin : g_addr_chk
    assign addr_ok = (coef_addr < AW'(N_TAPS));
  end

  assign wr_ok       = coef_we && (state_q == IDLE) && addr_ok;
  assign first_plane = (plane_q == PW'(IN_W - 1));

  // Current plane is always the MSB of each shifted sample.
  always_comb begin
    bits = '0;
    for (int k = 0; k < N_TAPS; k++) bits[k] = x_q[k][IN_W-1];
  end

  da_plane_sum #(
    .N_TAPS (N_TAPS),
    .COEF_W (COEF_W),
    .ACC_W  (ACC_W)
  ) u_plane_sum (
    .coef_i (coef_q),
    .bit_i  (bits),
    .sum_o  (psum)
  );

  // Two's complement samples weight the MSB plane negatively.
  always_comb begin
    if ((SIGNED_IN != 0) && first_plane) acc_step = (acc_q <<< 1) - psum;
    else                                 acc_step = (acc_q <<< 1) + psum;
  end

  always_comb begin
    wide = {{(WW-ACC_W){acc_step[ACC_W-1]}}, acc_step};
    res  = OUT_W'(wide >>> SHIFT);
  end

`ifdef DA_ROUND_EN
  localparam logic signed [WW-1:0] ONE  = 1;
  localparam logic signed [WW-1:0] RND  = WW'((2 ** SHIFT) / 2);
  localparam logic signed [WW-1:0] MAXV = (ONE <<< (OUT_W - 1)) - ONE;
  localparam logic signed [WW-1:0] MINV = -(ONE <<< (OUT_W - 1));

  logic signed [WW-1:0] rnd_sh;
  logic [OUT_W-1:0]     res_sat;
  logic                 sat, sat_q, sat_d;

  always_comb begin
    rnd_sh  = (wide + RND) >>> SHIFT;
    sat     = 1'b0;
    res_sat = OUT_W'(rnd_sh);
    if (rnd_sh > MAXV) begin
      res_sat = OUT_W'(MAXV);
      sat     = 1'b1;
    end else if (rnd_sh < MINV) begin
      res_sat = OUT_W'(MINV);
      sat     = 1'b1;
    end
  end
  assign sat_flag = sat_q;
`endif

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    acc_d   = acc_q;
    plane_d = plane_q;
    out_d   = out_q;
`ifdef DA_ROUND_EN
    sat_d   = sat_q;
`endif
    unique case (state_q)
      IDLE: if (in_valid) begin
        state_d = RUN;
        x_d     = in_data;
        acc_d   = '0;
        plane_d = PW'(IN_W - 1);
      end
      RUN: begin
        for (int k = 0; k < N_TAPS; k++) x_d[k] = x_q[k] << 1;
        acc_d   = acc_step;
        plane_d = plane_q - PW'(1);
        if (plane_q == '0) begin
          state_d = DONE;
`ifdef DA_ROUND_EN
          out_d   = res_sat;
          sat_d   = sat_q | sat;
`else
          out_d   = res;
`endif
        end
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      acc_q   <= '0;
      plane_q <= '0;
      out_q   <= '0;
      err_q   <= 1'b0;
`ifdef DA_ROUND_EN
      sat_q   <= 1'b0;
`endif
      for (int k = 0; k < N_TAPS; k++) coef_q[k] <= COEF_W'(COS16[k % 16]);
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      acc_q   <= acc_d;
      plane_q <= plane_d;
      out_q   <= out_d;
      err_q   <= coef_we & ~wr_ok;
`ifdef DA_ROUND_EN
      sat_q   <= sat_d;
`endif
      // An accept in the same cycle sees this write: RUN starts reading the table next cycle.
      if (wr_ok) coef_q[coef_addr] <= coef_wdata;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_data  = out_q;
  assign coef_err  = err_q;

endmodule

// File: tb/tb_da_dot_serial.sv
module tb_da_dot_serial;
  localparam int N = 16, IW = 8, CW = 19, SH = 2, OW = 28;
  localparam int COS [16] = '{131072, 121094, 92681, 50159, 0, -50159, -92681, -121094,
                              -131072, -121094, -92681, -50159, 0, 50159, 92681, 121094};

  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 1, coef_we = 0;
  logic [N*IW-1:0] in_data = '0;
  logic [3:0]      coef_addr = '0;
  logic [CW-1:0]   coef_wdata = '0;

  logic in_ready_s, coef_err_s, out_valid_s; logic [OW-1:0] out_data_s;
  logic in_ready_u, coef_err_u, out_valid_u; logic [OW-1:0] out_data_u;
  logic in_ready_t, coef_err_t, out_valid_t; logic [OW-1:0] out_data_t;
`ifdef DA_ROUND_EN
  logic sat_s, sat_u, sat_t;
`endif

  always #5 clk = ~clk;

  da_dot_serial u_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s), .in_data(in_data),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata), .coef_err(coef_err_s),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s)
`ifdef DA_ROUND_EN
    , .sat_flag(sat_s)
`endif
  );

  da_dot_serial #(.SIGNED_IN(0)) u_u (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_u), .in_data(in_data),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata), .coef_err(coef_err_u),
    .out_valid(out_valid_u), .out_ready(out_ready), .out_data(out_data_u)
`ifdef DA_ROUND_EN
    , .sat_flag(sat_u)
`endif
  );

  // 12-tap instance: exercises the out-of-range coefficient address rejection.
  da_dot_serial #(.N_TAPS(12)) u_t (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_t), .in_data(in_data[12*IW-1:0]),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata), .coef_err(coef_err_t),
    .out_valid(out_valid_t), .out_ready(out_ready), .out_data(out_data_t)
`ifdef DA_ROUND_EN
    , .sat_flag(sat_t)
`endif
  );

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int mc [N];
  int m_cnt;                     // 0 idle, 1..IW busy, IW+1 result pending
  logic [OW-1:0] m_out_s, m_out_u, m_pend_s, m_pend_u;
  bit m_err_s, m_err_t, m_sat_s, m_sat_u, m_psat_s, m_psat_u, started = 0;

  function automatic logic [OW-1:0] scale(input longint s, output bit sat);
    longint r;
    sat = 0;
`ifdef DA_ROUND_EN
    r = (s + ((longint'(1) <<< SH) / 2)) >>> SH;
    if (r > (longint'(1) <<< (OW-1)) - 1) begin r = (longint'(1) <<< (OW-1)) - 1; sat = 1; end
    else if (r < -(longint'(1) <<< (OW-1))) begin r = -(longint'(1) <<< (OW-1)); sat = 1; end
`else
    r = s >>> SH;
`endif
    return r[OW-1:0];
  endfunction

  always @(posedge clk) begin
    longint ss, su;
    bit idle;
    if (!rst_n) begin
      started = 1; m_cnt = 0; m_out_s = '0; m_out_u = '0;
      m_err_s = 0; m_err_t = 0; m_sat_s = 0; m_sat_u = 0;
      for (int k = 0; k < N; k++) mc[k] = COS[k];
    end else begin
      idle    = (m_cnt == 0);
      m_err_s = coef_we && !idle;
      m_err_t = coef_we && !(idle && coef_addr < 12);
      if (coef_we && idle) mc[coef_addr] = int'($signed(coef_wdata));
      if (idle) begin
        if (in_valid) begin
          ss = 0; su = 0;
          for (int k = 0; k < N; k++) begin
            ss += longint'(mc[k]) * longint'($signed(in_data[k*IW +: IW]));
            su += longint'(mc[k]) * longint'({1'b0, in_data[k*IW +: IW]});
          end
          m_pend_s = scale(ss, m_psat_s);
          m_pend_u = scale(su, m_psat_u);
          m_cnt = 1;
        end
      end else if (m_cnt < IW) m_cnt++;
      else if (m_cnt == IW) begin
        m_cnt++;
        m_out_s = m_pend_s; m_out_u = m_pend_u;
        m_sat_s |= m_psat_s; m_sat_u |= m_psat_u;
      end else if (out_ready) m_cnt = 0;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (started) begin
      chk("in_ready_s",  in_ready_s,  m_cnt == 0);
      chk("out_valid_s", out_valid_s, m_cnt == IW + 1);
      chk("out_data_s",  out_data_s,  m_out_s);
      chk("coef_err_s",  coef_err_s,  m_err_s);
      chk("in_ready_u",  in_ready_u,  m_cnt == 0);
      chk("out_valid_u", out_valid_u, m_cnt == IW + 1);
      chk("out_data_u",  out_data_u,  m_out_u);
      chk("coef_err_u",  coef_err_u,  m_err_s);
      chk("in_ready_t",  in_ready_t,  m_cnt == 0);
      chk("out_valid_t", out_valid_t, m_cnt == IW + 1);
      chk("coef_err_t",  coef_err_t,  m_err_t);
`ifdef DA_ROUND_EN
      chk("sat_s", sat_s, m_sat_s);
      chk("sat_u", sat_u, m_sat_u);
`endif
    end
  end

  // ---------------- directed stimulus ----------------
  function automatic logic [OW-1:0] o(input int v);
    logic [31:0] w;
    w = v;
    return w[OW-1:0];
  endfunction

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid_s && lat < 40) begin @(negedge clk); lat++; end
    if (lat >= 40) begin
      errors++; checks++;
      $display("FAIL timeout: out_valid never rose (waited %0d cycles)", lat);
    end
  endtask

  // Called just after a negedge with the engine idle; leaves it idle again.
  task automatic send(input logic [N*IW-1:0] x, input bit lit, input logic [OW-1:0] es,
                      input logic [OW-1:0] eu, output int lat);
    in_data = x; in_valid = 1;
    @(negedge clk);
    in_valid = 0; coef_we = 0;
    wait_valid(lat);
    if (lit) begin
      chk("lit_s", out_data_s, es);
      chk("lit_u", out_data_u, eu);
    end
    @(negedge clk);
  endtask

  task automatic wr(input int a, input int d);
    coef_addr = 4'(a); coef_wdata = CW'(d); coef_we = 1;
    @(negedge clk);
    coef_we = 0;
  endtask

  initial begin
    logic [N*IW-1:0] v;
    logic [OW-1:0] held;
    int lat;
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [N*IW-1:0] v;
    logic [OW-1:0] held;
    int lat;
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    chk("rst_in_ready", in_ready_s, 1'b1);
    chk("rst_out_valid", out_valid_s, 1'b0);
    chk("rst_out_data", out_data_s, '0);
    chk("rst_coef_err", coef_err_s, 1'b0);

    // all ones -> cosines cancel; latency 9
    v = '0;
    for (int k = 0; k < N; k++) v[k*IW +: IW] = 8'd1;
    send(v, 1, o(0), o(0), lat);
    chk("latency", 64'(lat), 64'd9);

    v = '0; v[7:0] = 8'd1;
    send(v, 1, o(32768), o(32768), lat);
    v = '0; v[7:0] = 8'h80;
    send(v, 1, o(-4194304), o(4194304), lat);
    v = '0; v[7:0] = 8'hFF;
    send(v, 1, o(-32768), o(8355840), lat);

    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < N; k++) v[k*IW +: IW] = 8'($urandom_range(0, 255));
      send(v, 0, '0, '0, lat);
    end

    // backpressure: result held, new vectors ignored
    out_ready = 0;
    v = '0; v[15:8] = 8'd3;
    in_data = v; in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    wait_valid(lat);
    held = out_data_s;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1; in_data = ~v;
      @(negedge clk);
      chk("bp_valid", out_valid_s, 1'b1);
      chk("bp_data", out_data_s, held);
      chk("bp_in_ready", in_ready_s, 1'b0);
    end
    in_valid = 0; out_ready = 1;
    @(negedge clk);
    chk("bp_release", in_ready_s, 1'b1);

    // write while busy is rejected, table unchanged
    v = '0; for (int k = 0; k < N; k++) v[k*IW +: IW] = 8'd2;
    in_data = v; in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    wr(2, 5);
    chk("busy_wr_err", coef_err_s, 1'b1);
    wait_valid(lat);
    @(negedge clk);
    v = '0; v[2*IW +: IW] = 8'd1;
    send(v, 1, o(23170), o(23170), lat);   // 92681>>>2 (round also 23170)

    // address 13: accepted by 16-tap, rejected by 12-tap
    wr(13, 1234);
    chk("addr_err_t", coef_err_t, 1'b1);
    chk("addr_ok_s", coef_err_s, 1'b0);

    // write in the accept cycle is used by that vector
    coef_addr = 4'd0; coef_wdata = CW'(1000); coef_we = 1;
    v = '0; v[7:0] = 8'd1;
    send(v, 1, o(250), o(250), lat);

    // reset in the middle of RUN
    wr(1, 7);
    v = '0; v[15:8] = 8'd1;
    in_data = v; in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    repeat (2) @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    chk("midrst_valid", out_valid_s, 1'b0);
    chk("midrst_ready", in_ready_s, 1'b1);
    repeat (10) @(negedge clk);
`ifdef DA_ROUND_EN
    send(v, 1, o(30274), o(30274), lat);
`else
    send(v, 1, o(30273), o(30273), lat);
`endif

    // tiny coefficient shows rounding vs floor
    wr(1, 3);
`ifdef DA_ROUND_EN
    send(v, 1, o(1), o(1), lat);
`else
    send(v, 1, o(0), o(0), lat);
`endif

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
